argmax_top2: RTL and testbench

- Parametrised successor of the FC3 argmax stage. Consumes a stream of NCLASS signed FC-layer scores and reports the top-1 and top-2 class indices, their scores, and a confidence margin.
- Supports any class count and data width.
- Sits after the final fully-connected layer and feeds the host/result register. Adds explicit busy/valid handshake and protocol-error detection.

---
 rtl/argmax_top2_pkg.sv | 15 +
 rtl/argmax_top2_insert.sv | 47 ++++
 rtl/argmax_top2.sv | 144 ++++++++++++++
 tb/tb_argmax_top2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_top2_pkg.sv
// Shared constants for the classifier back end: default score width, class count,
// most-negative score sentinel and the argmax FSM state encoding.
package argmax_top2_pkg;

  localparam int WD_DEF     = 16;
  localparam int NCLASS_DEF = 10;
  localparam logic signed [WD_DEF-1:0] MOST_NEG_DEF = {1'b1, {(WD_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_top2_insert.sv
// Combinational compare-insert of (q, idx) into the sorted pair {top1, top2}.
// Empty slots (v=0) always accept, so equal sentinel-valued scores still fill both.
module top2_insert #(
  parameter int WD = 16,
  parameter int IW = 4
) (
  input  logic signed [WD-1:0] i_q,
  input  logic        [IW-1:0] i_idx,
  input  logic                 i_v1,
  input  logic signed [WD-1:0] i_top1_val,
  input  logic        [IW-1:0] i_top1_idx,
  input  logic                 i_v2,
  input  logic signed [WD-1:0] i_top2_val,
  input  logic        [IW-1:0] i_top2_idx,
  output logic                 o_v1,
  output logic signed [WD-1:0] o_top1_val,
  output logic        [IW-1:0] o_top1_idx,
  output logic                 o_v2,
  output logic signed [WD-1:0] o_top2_val,
  output logic        [IW-1:0] o_top2_idx
);

  // Strict compares keep the earliest index on ties.
  always_comb begin
    o_v1       = i_v1;
    o_top1_val = i_top1_val;
    o_top1_idx = i_top1_idx;
    o_v2       = i_v2;
    o_top2_val = i_top2_val;
    o_top2_idx = i_top2_idx;
    if (!i_v1 || (i_q > i_top1_val)) begin
      o_v2       = i_v1;
      o_top2_val = i_top1_val;
      o_top2_idx = i_top1_idx;
      o_v1       = 1'b1;
      o_top1_val = i_q;
      o_top1_idx = i_idx;
    end else if (!i_v2 || (i_q > i_top2_val)) begin
      o_v2       = 1'b1;
      o_top2_val = i_q;
      o_top2_idx = i_idx;
    end else begin
      o_v1 = i_v1;
    end
  end

endmodule

// File: rtl/argmax_top2.sv
// Top-2 argmax over a stream of NCLASS signed scores with busy/valid handshake,
// registered confidence margin and sticky protocol-error flag.
module argmax_top2
  import argmax_top2_pkg::*;
#(
  parameter int WD     = WD_DEF,
  parameter int NCLASS = NCLASS_DEF,
  localparam int IW    = $clog2(NCLASS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [WD-1:0] q,
  input  logic                 q_en,
  output logic        [IW-1:0] top1_idx,
  output logic        [IW-1:0] top2_idx,
  output logic signed [WD-1:0] top1_val,
  output logic signed [WD-1:0] top2_val,
  output logic        [WD:0]   margin,
  output logic                 busy,
  output logic                 valid,
  output logic                 err
);

  localparam logic signed [WD-1:0] MOST_NEG = {1'b1, {(WD-1){1'b0}}};

  state_e                r_state;
  state_e                w_next;
  logic        [IW-1:0]  r_cnt;
  logic                  r_v1, r_v2;
  logic signed [WD-1:0]  r_top1_val, r_top2_val;
  logic        [IW-1:0]  r_top1_idx, r_top2_idx;
  logic        [WD:0]    r_margin;
  logic                  r_valid, r_err;
  logic                  w_busy, w_take, w_fin, w_last;
  logic                  w_n_v1, w_n_v2;
  logic signed [WD-1:0]  w_n_top1_val, w_n_top2_val;
  logic        [IW-1:0]  w_n_top1_idx, w_n_top2_idx;

  top2_insert #(.WD(WD), .IW(IW)) u_insert (
    .i_q        (q),
    .i_idx      (r_cnt),
    .i_v1       (r_v1),
    .i_top1_val (r_top1_val),
    .i_top1_idx (r_top1_idx),
    .i_v2       (r_v2),
    .i_top2_val (r_top2_val),
    .i_top2_idx (r_top2_idx),
    .o_v1       (w_n_v1),
    .o_top1_val (w_n_top1_val),
    .o_top1_idx (w_n_top1_idx),
    .o_v2       (w_n_v2),
    .o_top2_val (w_n_top2_val),
    .o_top2_idx (w_n_top2_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_ACC;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_ACC:  w_next = w_last ? ST_FIN : ST_ACC;
        ST_FIN:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State decode; start always wins over a coincident sample.
  always_comb begin
    w_busy = (r_state == ST_ACC);
    w_take = w_busy && q_en && !start;
    w_last = w_take && (r_cnt == IW'(NCLASS - 1));
    w_fin  = (r_state == ST_FIN) && !start;
  end

  // Tracking registers, margin, valid pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_top1_val <= '0;
      r_top2_val <= '0;
      r_top1_idx <= '0;
      r_top2_idx <= '0;
      r_margin   <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else if (start) begin
      r_cnt      <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_top1_val <= MOST_NEG;
      r_top2_val <= MOST_NEG;
      r_top1_idx <= '0;
      r_top2_idx <= '0;
      r_margin   <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= w_fin;
      if (w_take) begin
        r_v1       <= w_n_v1;
        r_v2       <= w_n_v2;
        r_top1_val <= w_n_top1_val;
        r_top2_val <= w_n_top2_val;
        r_top1_idx <= w_n_top1_idx;
        r_top2_idx <= w_n_top2_idx;
        if (!w_last) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_fin) begin
        r_margin <= {r_top1_val[WD-1], r_top1_val} - {r_top2_val[WD-1], r_top2_val};
      end
      if (q_en && !w_busy) begin
        r_err <= 1'b1;
      end
    end
  end

  assign top1_idx = r_top1_idx;
  assign top2_idx = r_top2_idx;
  assign top1_val = r_top1_val;
  assign top2_val = r_top2_val;
  assign margin   = r_margin;
  assign busy     = w_busy;
  assign valid    = r_valid;
  assign err      = r_err;

endmodule

// File: tb/tb_argmax_top2.sv
// Scoreboard bench for argmax_top2: directed cases on the default configuration
// plus random runs on WD/NCLASS variants, all checked against a reference top-2 model.
module tb_argmax_top2;

  typedef struct {
    int i1;
    int i2;
    int v1;
    int v2;
    int mg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic st [4];
  logic qen[4];
  int   sw_q;

  int   o_i1[4], o_i2[4], o_v1[4], o_v2[4], o_mg[4];
  logic o_busy[4], o_valid[4], o_err[4];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  logic [3:0] w0_i1, w0_i2; logic signed [15:0] w0_v1, w0_v2; logic [16:0] w0_mg;
  logic [3:0] w1_i1, w1_i2; logic signed [7:0]  w1_v1, w1_v2; logic [8:0]  w1_mg;
  logic [6:0] w2_i1, w2_i2; logic signed [23:0] w2_v1, w2_v2; logic [24:0] w2_mg;
  logic [0:0] w3_i1, w3_i2; logic signed [7:0]  w3_v1, w3_v2; logic [8:0]  w3_mg;

  argmax_top2 #(.WD(16), .NCLASS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .q(sw_q[15:0]), .q_en(qen[0]),
    .top1_idx(w0_i1), .top2_idx(w0_i2), .top1_val(w0_v1), .top2_val(w0_v2),
    .margin(w0_mg), .busy(o_busy[0]), .valid(o_valid[0]), .err(o_err[0]));
  argmax_top2 #(.WD(8), .NCLASS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .q(sw_q[7:0]), .q_en(qen[1]),
    .top1_idx(w1_i1), .top2_idx(w1_i2), .top1_val(w1_v1), .top2_val(w1_v2),
    .margin(w1_mg), .busy(o_busy[1]), .valid(o_valid[1]), .err(o_err[1]));
  argmax_top2 #(.WD(24), .NCLASS(100)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .q(sw_q[23:0]), .q_en(qen[2]),
    .top1_idx(w2_i1), .top2_idx(w2_i2), .top1_val(w2_v1), .top2_val(w2_v2),
    .margin(w2_mg), .busy(o_busy[2]), .valid(o_valid[2]), .err(o_err[2]));
  argmax_top2 #(.WD(8), .NCLASS(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .q(sw_q[7:0]), .q_en(qen[3]),
    .top1_idx(w3_i1), .top2_idx(w3_i2), .top1_val(w3_v1), .top2_val(w3_v2),
    .margin(w3_mg), .busy(o_busy[3]), .valid(o_valid[3]), .err(o_err[3]));

  assign o_i1[0] = int'(w0_i1); assign o_i2[0] = int'(w0_i2);
  assign o_v1[0] = int'(w0_v1); assign o_v2[0] = int'(w0_v2); assign o_mg[0] = int'(w0_mg);
  assign o_i1[1] = int'(w1_i1); assign o_i2[1] = int'(w1_i2);
  assign o_v1[1] = int'(w1_v1); assign o_v2[1] = int'(w1_v2); assign o_mg[1] = int'(w1_mg);
  assign o_i1[2] = int'(w2_i1); assign o_i2[2] = int'(w2_i2);
  assign o_v1[2] = int'(w2_v1); assign o_v2[2] = int'(w2_v2); assign o_mg[2] = int'(w2_mg);
  assign o_i1[3] = int'(w3_i1); assign o_i2[3] = int'(w3_i2);
  assign o_v1[3] = int'(w3_v1); assign o_v2[3] = int'(w3_v2); assign o_mg[3] = int'(w3_mg);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: top1 = earliest maximum; top2 = earliest maximum among the rest.
  function automatic exp_t model(input int s[$]);
    exp_t e;
    int   a, b;
    a = 0;
    for (int i = 1; i < s.size(); i++) if (s[i] > s[a]) a = i;
    b = (a == 0) ? 1 : 0;
    for (int i = 0; i < s.size(); i++) if (i != a && s[i] > s[b]) b = i;
    e.i1 = a; e.i2 = b; e.v1 = s[a]; e.v2 = s[b]; e.mg = s[a] - s[b];
    return e;
  endfunction

  function automatic int rnd_score(input int wd);
    int r;
    r = int'($urandom);
    return r >>> (32 - wd);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int sel, input int s[$], input bit with_start);
    int   lat;
    exp_t e;
    if (with_start) begin
      st[sel] = 1'b1;
      tick();
      st[sel] = 1'b0;
    end
    chk("busy_in_acc", 32'(o_busy[sel]), 32'd1);
    foreach (s[i]) begin
      qen[sel] = 1'b1;
      sw_q     = s[i];
      tick();
    end
    qen[sel] = 1'b0;
    sb.push_back(model(s));
    chk("busy_in_fin", 32'(o_busy[sel]), 32'd0);
    lat = 0;
    while (!o_valid[sel] && lat < 8) begin
      tick();
      lat++;
    end
    chk("valid_latency", lat, 32'd1);
    chk("busy_at_valid", 32'(o_busy[sel]), 32'd0);
    e = sb.pop_front();
    chk("top1_idx", o_i1[sel], e.i1);
    chk("top2_idx", o_i2[sel], e.i2);
    chk("top1_val", o_v1[sel], e.v1);
    chk("top2_val", o_v2[sel], e.v2);
    chk("margin",   o_mg[sel], e.mg);
    chk("err_clean", 32'(o_err[sel]), 32'd0);
    tick();
    chk("valid_one_cycle", 32'(o_valid[sel]), 32'd0);
    chk("top1_val_hold", o_v1[sel], e.v1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int s[$];
    int vcount;
    rst_n = 1'b0;
    sw_q  = 0;
    for (int k = 0; k < 4; k++) begin st[k] = 1'b0; qen[k] = 1'b0; end
    tick();
    tick();
    chk("rst_top1_idx", o_i1[0], 32'd0);
    chk("rst_top2_idx", o_i2[0], 32'd0);
    chk("rst_top1_val", o_v1[0], 32'd0);
    chk("rst_top2_val", o_v2[0], 32'd0);
    chk("rst_margin",   o_mg[0], 32'd0);
    chk("rst_busy",  32'(o_busy[0]),  32'd0);
    chk("rst_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_err",   32'(o_err[0]),   32'd0);
    rst_n = 1'b1;
    tick();

    s = {};
    for (int i = 0; i < 10; i++) s.push_back(10 * i);
    run_seq(0, s, 1'b1);
    chk("seq_top1_idx_const", o_i1[0], 32'd9);
    chk("seq_margin_const",   o_mg[0], 32'd10);

    s = {5, -3, 7, 7, 2, 1, 0, -2, 4, -1};
    run_seq(0, s, 1'b1);

    s = {};
    for (int i = 0; i < 10; i++) s.push_back(-32768);
    run_seq(0, s, 1'b1);

    s[4] = 32767;
    run_seq(0, s, 1'b1);
    chk("wide_margin_const", o_mg[0], 32'h0000_FFFF);

    // Restart: start coincides with the idx-5 sample, which must be dropped.
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      qen[0] = 1'b1;
      sw_q   = 1000 + i;
      tick();
    end
    st[0]  = 1'b1;
    qen[0] = 1'b1;
    sw_q   = 30000;
    tick();
    st[0]  = 1'b0;
    qen[0] = 1'b0;
    chk("restart_err", 32'(o_err[0]), 32'd0);
    s = {};
    for (int i = 0; i < 10; i++) s.push_back($urandom_range(200) - 100);
    run_seq(0, s, 1'b0);

    // Protocol error: sample while idle.
    qen[0] = 1'b1;
    sw_q   = 5;
    tick();
    qen[0] = 1'b0;
    chk("err_set", 32'(o_err[0]), 32'd1);
    tick();
    tick();
    chk("err_sticky", 32'(o_err[0]), 32'd1);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    chk("err_cleared", 32'(o_err[0]), 32'd0);

    // Asynchronous reset in the middle of accumulation.
    for (int i = 0; i < 3; i++) begin
      qen[0] = 1'b1;
      sw_q   = 50 + i;
      tick();
    end
    qen[0] = 1'b0;
    rst_n  = 1'b0;
    #2;
    chk("abort_top1_val", o_v1[0], 32'd0);
    chk("abort_top1_idx", o_i1[0], 32'd0);
    chk("abort_busy", 32'(o_busy[0]), 32'd0);
    tick();
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_valid[0]) vcount++;
    end
    chk("abort_no_valid", vcount, 32'd0);

    // Parameter sweep with random signed scores.
    for (int r = 0; r < 4; r++) begin
      s = {};
      for (int i = 0; i < 16; i++) s.push_back(rnd_score(8));
      run_seq(1, s, 1'b1);
      s = {};
      for (int i = 0; i < 100; i++) s.push_back(rnd_score(24));
      run_seq(2, s, 1'b1);
      s = {};
      for (int i = 0; i < 2; i++) s.push_back(rnd_score(8));
      run_seq(3, s, 1'b1);
    end
    s = {-128, 127};
    run_seq(3, s, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
